// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - in-order FIFO of IF predictions retired and checked against the WB next PC
//
// Purpose: holds {pc, pred_pc} for every instruction IF issues with a prediction, compares the
// head entry against the committed next PC at WB, and on a mismatch empties the FIFO and holds
// flush/redirect_pc for FLUSH_CYCLES cycles.
//
// Ports:
//   clk, rst                      clock; synchronous active-low reset
//   if_fire, if_pc, if_pred_pc    IF enqueue request (accepted when if_ready)
//   if_ready                      RUN state and FIFO not full (from registered count)
//   wb_valid, wb_pc, wb_next_pc   WB commit used to retire the head entry
//   flush, redirect_pc            registered squash/redirect, valid for FLUSH_CYCLES cycles
//   seq_err                       sticky: WB with empty FIFO or WB pc not matching head pc
//   pred_total, mispred_total     statistics counters
//
// Optional feature: define BRANCH_RESOLVER_STATS_EN to build the statistics counters;
// otherwise pred_total and mispred_total are constant 0.

module branch_resolver #(
    parameter int DEPTH        = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_fire,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_pred_pc,
    output logic        if_ready,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_next_pc,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        seq_err,
    output logic [31:0] pred_total,
    output logic [31:0] mispred_total
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic [FW-1:0]  flush_cnt;
    logic [31:0]    redirect_q;
    logic           seq_err_q;

    logic [31:0]    pc_mem   [DEPTH];
    logic [31:0]    pred_mem [DEPTH];

    logic           enq;
    logic           deq;
    logic           mispred;
    logic           order_err;

    assign if_ready  = (state == RUN) && (count < CW'(DEPTH));
    assign enq       = if_fire && if_ready;
    assign deq       = wb_valid && (state == RUN) && (count != '0);
    assign mispred   = deq && (pred_mem[rd_ptr] != wb_next_pc);
    // Empty-FIFO WB and head/pc mismatch are both ordering faults; wrong-path WB in FLUSH is not.
    assign order_err = wb_valid && (state == RUN) &&
                       ((count == '0) || (pc_mem[rd_ptr] != wb_pc));

    assign flush       = (state == FLUSH);
    assign redirect_pc = redirect_q;
    assign seq_err     = seq_err_q;

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (mispred) state_nxt = FLUSH;
            FLUSH:   if (flush_cnt == '0) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            flush_cnt  <= '0;
            redirect_q <= '0;
            seq_err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (order_err) seq_err_q <= 1'b1;

            if (mispred) begin
                // Empty the FIFO; a same-cycle enqueue is wrong-path and is dropped.
                rd_ptr     <= rd_ptr + PW'(1);
                wr_ptr     <= rd_ptr + PW'(1);
                count      <= '0;
                redirect_q <= wb_next_pc;
                flush_cnt  <= FW'(FLUSH_CYCLES - 1);
            end else begin
                if (enq) wr_ptr <= wr_ptr + PW'(1);
                if (deq) rd_ptr <= rd_ptr + PW'(1);
                case ({enq, deq})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
                if ((state == FLUSH) && (flush_cnt != '0)) flush_cnt <= flush_cnt - FW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (enq && !mispred) begin
            pc_mem[wr_ptr]   <= if_pc;
            pred_mem[wr_ptr] <= if_pred_pc;
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] pred_q;
    logic [31:0] mispred_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pred_q    <= '0;
            mispred_q <= '0;
        end else begin
            if (deq)     pred_q    <= pred_q + 32'd1;
            if (mispred) mispred_q <= mispred_q + 32'd1;
        end
    end

    assign pred_total    = pred_q;
    assign mispred_total = mispred_q;
`else
    assign pred_total    = 32'd0;
    assign mispred_total = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed self-checking bench for branch_resolver

module tb_branch_resolver;

    logic        clk;
    logic        rst;
    logic        if_fire;
    logic [31:0] if_pc;
    logic [31:0] if_pred_pc;
    logic        if_ready;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_next_pc;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        seq_err;
    logic [31:0] pred_total;
    logic [31:0] mispred_total;

    int total;
    int bad;

`ifdef BRANCH_RESOLVER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    branch_resolver #(.DEPTH(8), .FLUSH_CYCLES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_fire       (if_fire),
        .if_pc         (if_pc),
        .if_pred_pc    (if_pred_pc),
        .if_ready      (if_ready),
        .wb_valid      (wb_valid),
        .wb_pc         (wb_pc),
        .wb_next_pc    (wb_next_pc),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .seq_err       (seq_err),
        .pred_total    (pred_total),
        .mispred_total (mispred_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_fire  = 1'b0;
        wb_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        step();
        rst = 1'b1;
    endtask

    task automatic enq(input logic [31:0] pc, input logic [31:0] pred);
        if_fire = 1'b1; if_pc = pc; if_pred_pc = pred; wb_valid = 1'b0;
        step();
        if_fire = 1'b0;
    endtask

    task automatic wb(input logic [31:0] pc, input logic [31:0] nxt);
        wb_valid = 1'b1; wb_pc = pc; wb_next_pc = nxt; if_fire = 1'b0;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if_fire = 1'($urandom); if_pc = $urandom; if_pred_pc = $urandom;
            wb_valid = 1'($urandom); wb_pc = $urandom; wb_next_pc = $urandom;
            step();
        end
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL reset_if_ready got=%b exp=1", if_ready); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", flush); end
        total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_redirect got=%h exp=0", redirect_pc); end
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL reset_seq_err got=%b exp=0", seq_err); end
        total++; if (pred_total !== 32'h0 || mispred_total !== 32'h0) begin
            bad++; $display("FAIL reset_counters got=%h/%h exp=0/0", pred_total, mispred_total);
        end
        rst = 1'b1;
        idle();
        step();
    endtask

    task automatic test_fill_drain();
        logic ready_exp;
        for (int i = 0; i < 8; i++) begin
            enq(32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i));
            ready_exp = (i < 7);
            total++; if (if_ready !== ready_exp) begin
                bad++; $display("FAIL fill_ready_%0d got=%b exp=%b", i, if_ready, ready_exp);
            end
        end
        enq(32'h120, 32'h124);
        total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL fill_9th_dropped got=%b exp=0", if_ready); end
        for (int i = 0; i < 8; i++) begin
            wb(32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i));
            total++; if (flush !== 1'b0 || if_ready !== 1'b1) begin
                bad++; $display("FAIL drain_%0d flush=%b ready=%b exp 0/1", i, flush, if_ready);
            end
        end
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL drain_seq_err got=%b exp=0", seq_err); end
        total++; if (pred_total !== (STATS ? 32'd8 : 32'd0)) begin
            bad++; $display("FAIL drain_pred_total got=%0d exp=%0d", pred_total, STATS ? 8 : 0);
        end
    endtask

    task automatic test_mispredict();
        enq(32'h200, 32'h204);
        enq(32'h204, 32'h208);
        wb(32'h200, 32'h300);
        // Wrong-path WB during FLUSH must be ignored.
        wb_valid = 1'b1; wb_pc = 32'hdead0000; wb_next_pc = 32'h1;
        for (int c = 0; c < 2; c++) begin
            total++; if (flush !== 1'b1 || redirect_pc !== 32'h300 || if_ready !== 1'b0) begin
                bad++; $display("FAIL mis_flush_cyc%0d flush=%b redir=%h ready=%b exp 1/300/0",
                                c, flush, redirect_pc, if_ready);
            end
            step();
        end
        wb_valid = 1'b0;
        total++; if (flush !== 1'b0 || if_ready !== 1'b1) begin
            bad++; $display("FAIL mis_back_to_run flush=%b ready=%b exp 0/1", flush, if_ready);
        end
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL mis_wrongpath_seq_err got=%b exp=0", seq_err); end
        total++; if (mispred_total !== (STATS ? 32'd1 : 32'd0) || pred_total !== (STATS ? 32'd9 : 32'd0)) begin
            bad++; $display("FAIL mis_counters got=%0d/%0d exp=%0d/%0d", mispred_total, pred_total,
                            STATS ? 1 : 0, STATS ? 9 : 0);
        end
        // If the 0x204 entry had survived it would be the head and trip seq_err.
        enq(32'h210, 32'h214);
        wb(32'h210, 32'h214);
        total++; if (seq_err !== 1'b0 || flush !== 1'b0) begin
            bad++; $display("FAIL mis_fifo_emptied seq_err=%b flush=%b exp 0/0", seq_err, flush);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) enq(32'h500 + 32'(4 * i), 32'h504 + 32'(4 * i));
        if_fire = 1'b1; if_pc = 32'h600; if_pred_pc = 32'h604;
        wb_valid = 1'b1; wb_pc = 32'h500; wb_next_pc = 32'h504;
        step();
        idle();
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL sim_full_count7 ready=%b exp=1", if_ready); end
        for (int i = 1; i < 5; i++) wb(32'h500 + 32'(4 * i), 32'h504 + 32'(4 * i));
        // count is now 3: enqueue and retire together.
        if_fire = 1'b1; if_pc = 32'h700; if_pred_pc = 32'h704;
        wb_valid = 1'b1; wb_pc = 32'h514; wb_next_pc = 32'h518;
        step();
        idle();
        for (int i = 0; i < 5; i++) begin
            enq(32'h704 + 32'(4 * i), 32'h708 + 32'(4 * i));
            total++; if (if_ready !== (i < 4)) begin
                bad++; $display("FAIL sim_count3_fill_%0d ready=%b exp=%b", i, if_ready, i < 4);
            end
        end
        wb(32'h518, 32'h51c);
        wb(32'h51c, 32'h520);
        wb(32'h700, 32'h704);
        for (int i = 0; i < 5; i++) wb(32'h704 + 32'(4 * i), 32'h708 + 32'(4 * i));
        total++; if (seq_err !== 1'b0 || flush !== 1'b0) begin
            bad++; $display("FAIL sim_drain seq_err=%b flush=%b exp 0/0", seq_err, flush);
        end
        // Enqueue during a mispredicting WB is lost.
        enq(32'h800, 32'h804);
        if_fire = 1'b1; if_pc = 32'h804; if_pred_pc = 32'h808;
        wb_valid = 1'b1; wb_pc = 32'h800; wb_next_pc = 32'h900;
        step();
        idle();
        total++; if (flush !== 1'b1 || redirect_pc !== 32'h900) begin
            bad++; $display("FAIL sim_mis_flush flush=%b redir=%h exp 1/900", flush, redirect_pc);
        end
        step();
        step();
        enq(32'hA00, 32'hA04);
        wb(32'hA00, 32'hA04);
        total++; if (seq_err !== 1'b0 || flush !== 1'b0) begin
            bad++; $display("FAIL sim_mis_enq_lost seq_err=%b flush=%b exp 0/0", seq_err, flush);
        end
    endtask

    task automatic test_errors_and_reset_mid_flush();
        do_reset();
        enq(32'h200, 32'h204);
        wb(32'h400, 32'h300);
        total++; if (seq_err !== 1'b1) begin bad++; $display("FAIL err_order seq_err=%b exp=1", seq_err); end
        total++; if (flush !== 1'b1 || redirect_pc !== 32'h300) begin
            bad++; $display("FAIL err_order_still_checks flush=%b redir=%h exp 1/300", flush, redirect_pc);
        end
        // First flush cycle: reset here.
        rst = 1'b0;
        step();
        rst = 1'b1;
        total++; if (flush !== 1'b0 || if_ready !== 1'b1 || seq_err !== 1'b0 || redirect_pc !== 32'h0) begin
            bad++; $display("FAIL rst_mid_flush flush=%b ready=%b seq_err=%b redir=%h exp 0/1/0/0",
                            flush, if_ready, seq_err, redirect_pc);
        end
        // count must be 0: a WB now is an empty-FIFO error with no flush.
        wb(32'h200, 32'h204);
        total++; if (seq_err !== 1'b1 || flush !== 1'b0) begin
            bad++; $display("FAIL err_empty_wb seq_err=%b flush=%b exp 1/0", seq_err, flush);
        end
        step();
        total++; if (seq_err !== 1'b1) begin bad++; $display("FAIL err_sticky seq_err=%b exp=1", seq_err); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        if_fire = 1'b0; if_pc = '0; if_pred_pc = '0;
        wb_valid = 1'b0; wb_pc = '0; wb_next_pc = '0;
        #1;
        test_reset();
        test_fill_drain();
        test_mispredict();
        test_simultaneous();
        test_errors_and_reset_mid_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
